// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction memory address and fills the IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        fetch_err
);

    logic [31:0] pc_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_inst_r;
    logic        id_valid_r;
    logic        fetch_err_r;

    logic [31:0] pc_nxt_s;
    logic [31:0] id_pc_nxt_s;
    logic [31:0] id_inst_nxt_s;
    logic        id_valid_nxt_s;
    logic        fetch_err_nxt_s;
    logic [31:0] target_s;
    logic        misaligned_s;
    logic        frozen_s;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & 32'h0000_0003) != 32'h0000_0000;
    endfunction

    assign target_s = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHK_EN
    assign misaligned_s = is_misaligned(redirect_pc);
    assign frozen_s     = fetch_err_r;
`else
    assign misaligned_s = 1'b0;
    assign frozen_s     = 1'b0;
`endif

    // Next-state selection: redirect beats stall, stall beats normal advance.
    always_comb begin
        pc_nxt_s        = pc_r;
        id_pc_nxt_s     = id_pc_r;
        id_inst_nxt_s   = id_inst_r;
        id_valid_nxt_s  = id_valid_r;
        fetch_err_nxt_s = fetch_err_r;
        if (frozen_s) begin
            // Trapped: keep the PC and keep a bubble in IF/ID until reset.
            id_inst_nxt_s  = NOP_INST;
            id_valid_nxt_s = 1'b0;
        end else if (redirect) begin
            id_pc_nxt_s    = pc_r;
            id_inst_nxt_s  = NOP_INST;
            id_valid_nxt_s = 1'b0;
            if (misaligned_s) begin
                fetch_err_nxt_s = 1'b1;
            end else begin
                pc_nxt_s = target_s;
            end
        end else if (stall) begin
            pc_nxt_s = pc_r;
        end else begin
            pc_nxt_s       = pc_r + 32'd4;
            id_pc_nxt_s    = pc_r;
            id_inst_nxt_s  = imem_inst;
            id_valid_nxt_s = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC & 32'hFFFF_FFFC;
            id_pc_r     <= 32'h0000_0000;
            id_inst_r   <= NOP_INST;
            id_valid_r  <= 1'b0;
            fetch_err_r <= 1'b0;
        end else begin
            pc_r        <= pc_nxt_s;
            id_pc_r     <= id_pc_nxt_s;
            id_inst_r   <= id_inst_nxt_s;
            id_valid_r  <= id_valid_nxt_s;
            fetch_err_r <= fetch_err_nxt_s;
        end
    end

    assign imem_addr = pc_r;
    assign id_pc     = id_pc_r;
    assign id_inst   = id_inst_r;
    assign id_valid  = id_valid_r;
    assign fetch_err = fetch_err_r;

    fetch_stage_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc_r),
        .id_valid (id_valid_r),
        .fetch_err(fetch_err_r)
    );

endmodule

// Run-time invariants of the fetch stage.
module fetch_stage_chk (
    input logic        clk,
    input logic        rst,
    input logic [31:0] pc,
    input logic        id_valid,
    input logic        fetch_err
);

    a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
        (pc & 32'h0000_0003) == 32'h0000_0000);

    a_err_no_valid: assert property (@(posedge clk) disable iff (rst)
        fetch_err |-> !id_valid);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem modelled as mem[addr>>2] = 32'h1000_0000 + index.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        fetch_err;

    int n_checks;
    int n_errors;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_inst  (imem_inst),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .fetch_err  (fetch_err)
    );

    assign imem_inst = 32'h1000_0000 + (imem_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, imem_addr, 32'h0000_0000);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_inst"}, id_inst, 32'h0000_0013);
        check({tag, "_pc"}, id_pc, 32'h0000_0000);
        check({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        step();
        check_reset_state("reset");

        // Straight-line fetch
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_pc", id_pc, 32'(i) * 32'd4);
            check("seq_inst", id_inst, 32'h1000_0000 + 32'(i));
            check("seq_valid", {31'd0, id_valid}, 32'd1);
        end
        check("seq_addr", imem_addr, 32'h0000_000C);

        // Stall holds everything
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h0000_000C);
            check("stall_pc", id_pc, 32'h0000_0008);
            check("stall_inst", id_inst, 32'h1000_0002);
            check("stall_valid", {31'd0, id_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        check("rel_pc", id_pc, 32'h0000_000C);
        check("rel_inst", id_inst, 32'h1000_0003);
        check("rel_addr", imem_addr, 32'h0000_0010);

        // Redirect wins over stall
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        check("redir_addr", imem_addr, 32'h0000_0040);
        check("redir_valid", {31'd0, id_valid}, 32'd0);
        check("redir_inst", id_inst, 32'h0000_0013);
        check("redir_idpc", id_pc, 32'h0000_0010);
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        check("tgt_pc", id_pc, 32'h0000_0040);
        check("tgt_inst", id_inst, 32'h1000_0010);
        check("tgt_valid", {31'd0, id_valid}, 32'd1);

        // PC wraps modulo 2^32
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_inst", id_inst, 32'h4FFF_FFFF);
        check("wrap_err", {31'd0, fetch_err}, 32'd0);
        step();
        check("post_wrap_pc", id_pc, 32'h0000_0000);
        check("post_wrap_inst", id_inst, 32'h1000_0000);

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0042;
        step();
`ifdef FETCH_ALIGN_CHK_EN
        check("mis_err", {31'd0, fetch_err}, 32'd1);
        check("mis_addr", imem_addr, 32'h0000_0004);
        check("mis_valid", {31'd0, id_valid}, 32'd0);
        check("mis_inst", id_inst, 32'h0000_0013);
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            redirect = (i == 2) ? 1'b1 : 1'b0;
            step();
            check("frz_err", {31'd0, fetch_err}, 32'd1);
            check("frz_addr", imem_addr, 32'h0000_0004);
            check("frz_valid", {31'd0, id_valid}, 32'd0);
        end
        redirect = 1'b0;
`else
        check("mis_addr", imem_addr, 32'h0000_0040);
        check("mis_err", {31'd0, fetch_err}, 32'd0);
        check("mis_valid", {31'd0, id_valid}, 32'd0);
        redirect = 1'b0;
        step();
        check("mis_tgt_pc", id_pc, 32'h0000_0040);
        check("mis_tgt_inst", id_inst, 32'h1000_0010);
        check("mis_tgt_valid", {31'd0, id_valid}, 32'd1);
`endif

        // Reset overrides stall and redirect
        rst         = 1'b1;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        step();
        check_reset_state("rst2");
        rst      = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        check("after_rst_pc", id_pc, 32'h0000_0000);
        check("after_rst_inst", id_inst, 32'h1000_0000);
        check("after_rst_valid", {31'd0, id_valid}, 32'd1);
        check("after_rst_addr", imem_addr, 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
